// File: rtl/node_loader.sv
// node_loader: packs a narrow word stream into node weight/bias/input buses and returns the node result.
// Optional FRAME_CHECK_EN: reject beats whose kind differs from the frame kind and raise sticky err.
module node_loader #(
  parameter int N_INPUTS     = 16,
  parameter int WEIGHT_BITS  = 6,
  parameter int INPUT_BITS   = 6,
  parameter int OUTPUT_BITS  = 1,
  parameter int NODE_LATENCY = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic                            s_kind,
  input  logic [WEIGHT_BITS-1:0]          s_data,
  output logic [N_INPUTS*WEIGHT_BITS-1:0] weights_t,
  output logic [WEIGHT_BITS-1:0]          bias_t,
  output logic [N_INPUTS*INPUT_BITS-1:0]  inputs_t,
  input  logic [OUTPUT_BITS-1:0]          node_outputs,
  output logic                            r_valid,
  input  logic                            r_ready,
  output logic [OUTPUT_BITS-1:0]          r_data,
  output logic                            busy,
  output logic                            err
);
  localparam int CMAX = N_INPUTS > NODE_LATENCY ? N_INPUTS : NODE_LATENCY;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] LAST_X = CW'(N_INPUTS - 1);
  localparam logic [CW-1:0] BIAS_IDX = CW'(N_INPUTS);
  localparam logic [CW-1:0] LAT = CW'(NODE_LATENCY);
  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, WAIT, RESP} state_t;
  state_t                          state_q;
  logic [CW-1:0]                   cnt_q;
  logic                            kind_q;
  logic [N_INPUTS*WEIGHT_BITS-1:0] weights_q;
  logic [WEIGHT_BITS-1:0]          bias_q;
  logic [N_INPUTS*INPUT_BITS-1:0]  inputs_q;
  logic [OUTPUT_BITS-1:0]          r_data_q;
  logic                            r_valid_q;
  logic                            beat;
  logic                            kind;
  logic                            mism;
  logic [CW-1:0]                   idx;
  assign s_ready   = state_q == IDLE || state_q == LOAD_W || state_q == LOAD_X;
  assign beat      = s_valid && s_ready;
  assign idx       = state_q == IDLE ? '0 : cnt_q;
  assign kind      = state_q == IDLE ? s_kind : kind_q;
  assign busy      = state_q != IDLE;
  assign weights_t = weights_q;
  assign bias_t    = bias_q;
  assign inputs_t  = inputs_q;
  assign r_data    = r_data_q;
  assign r_valid   = r_valid_q;
`ifdef FRAME_CHECK_EN
  logic err_q;
  assign mism = state_q != IDLE && s_kind != kind_q;
  assign err  = err_q;
`else
  assign mism = 1'b0;
  assign err  = 1'b0;
`endif
  // IDLE accepts word 0 of a frame, so IDLE and LOAD_* share the beat path with idx forced to 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      kind_q    <= 1'b0;
      weights_q <= '0;
      bias_q    <= '0;
      inputs_q  <= '0;
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
`ifdef FRAME_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, LOAD_W, LOAD_X: if (beat) begin
          if (mism) begin
            cnt_q   <= '0;
            state_q <= IDLE;
`ifdef FRAME_CHECK_EN
            err_q   <= 1'b1;
`endif
          end else if (!kind) begin
            kind_q <= kind;
            if (idx == BIAS_IDX) begin
              bias_q  <= s_data;
              cnt_q   <= '0;
              state_q <= IDLE;
            end else begin
              weights_q[idx*WEIGHT_BITS +: WEIGHT_BITS] <= s_data;
              cnt_q   <= idx + 1'b1;
              state_q <= LOAD_W;
            end
          end else begin
            kind_q <= kind;
            inputs_q[idx*INPUT_BITS +: INPUT_BITS] <= s_data[INPUT_BITS-1:0];
            cnt_q   <= idx == LAST_X ? '0 : idx + 1'b1;
            state_q <= idx == LAST_X ? WAIT : LOAD_X;
          end
        end
        WAIT: if (cnt_q == LAT) begin
          r_data_q  <= node_outputs;
          r_valid_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= RESP;
        end else cnt_q <= cnt_q + 1'b1;
        RESP: if (r_ready) begin
          r_valid_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
